bram_add_sequencer: RTL and testbench
=====================================

// Module: bram_add_sequencer
// PURPOSE
//  Sequences the three 256x16 single-port BRAMs of the adder datapath: streams operand words from
//  BRAM1 and BRAM2, adds them and writes each sum to BRAM3 at the same address, one element per cycle.
//  Sits between the top-level control (start/done) and the bram1/bram2/bram3 wrappers.
//  It is the only driver of their ena/wea/addr/din pins.
// PARAMETERS
//  AW      8  BRAM address width (depth 2**AW)
//  DW      16 data word width
//  RD_LAT  1  BRAM read latency in cycles, address to dout (1 or 2)
// PORTS
//  clk      in  1     single clock; all BRAMs share it
//  rst      in  1     synchronous, active-high reset
//  start    in  1     pulse; sampled only in IDLE
//  base     in  AW    first element address; latched on start
//  len      in  AW+1  element count, 0..2**AW; latched on start
//  busy     out 1     high from the cycle after start accept until the last write cycle
//  done     out 1     one-cycle pulse after the last write
//  ovf      out 1     sticky: any sum carried out of DW bits this run; cleared on start accept
//  ena1     out 1     BRAM1 enable (read only, wea1 tied 0 outside this block)
//  ena2     out 1     BRAM2 enable
//  addra12  out AW    shared read address for BRAM1/BRAM2
//  douta1   in  DW    BRAM1 read data
//  douta2   in  DW    BRAM2 read data
//  ena3     out 1     BRAM3 enable
//  wea3     out 1     BRAM3 write enable
//  addra3   out AW    BRAM3 write address
//  dina3    out DW    BRAM3 write data (sum)
// BEHAVIOUR
//  - Reset: all outputs 0 and FSM in IDLE at the next edge. A run in progress is abandoned: no further
//    enables or writes, and done is not pulsed.
//  - FSM states:
//    IDLE  -start-> RUN (len>0) or DONE (len==0).
//    RUN   -last address issued-> DRAIN.
//    DRAIN -last write issued-> DONE.
//    DONE  -> IDLE unconditionally, 1 cycle, done=1.
//  - Timing: start accepted in cycle 0.
//    Reads: cycles 1..len, addra12 = base+i, ena1 = ena2 = 1.
//    Writes: douta1/douta2 for element i are valid RD_LAT cycles later; sum registered;
//    ena3 = wea3 = 1 with addra3 = base+i in cycle i+RD_LAT+1.
//    Last write in cycle len+RD_LAT. done in cycle len+RD_LAT+1.
//    busy covers cycles 1..len+RD_LAT. Throughput is 1 element/cycle with no bubbles.
//  - Arithmetic: dina3 = (douta1 + douta2) mod 2**DW. The carry bit ORs into ovf.
//  - Addresses wrap modulo 2**AW: base=250, len=10 touches 250..255, 0..3.
//  - len == 0: no BRAM enable asserted; done pulses in cycle 1; ovf cleared.
//  - start while not IDLE: ignored, latched base/len unchanged. start coincident with rst: rst wins.
//  - Outside a run, ena1/ena2/ena3/wea3 = 0. addra/dina hold their last value (don't care).
// STRUCTURE
//  - Package bram_add_pkg holds AW/DW defaults, the state enum {IDLE,RUN,DRAIN,DONE} and a
//    localparam for the max length.
//  - Sub-module bram_add_delay_line (DEPTH=RD_LAT+1) carries {valid, addr} from the read issue stage
//    to the write stage. It is reset to valid=0.
//  - This block adds the read counter, FSM, adder/sum register and ovf flag.
// TESTING
//  - Bench: behavioural 256x16 BRAM models with RD_LAT=1 and 2, plus a scoreboard.
//  1. BRAM1[i]=i, BRAM2[i]=2i. Start with base=0, len=4.
//     -> BRAM3[0..3] = 0,3,6,9. done in cycle 6 (RD_LAT=1). ovf=0.
//  2. BRAM1[5]=16'hFFFF, BRAM2[5]=16'h0002. Start with base=5, len=1.
//     -> BRAM3[5] = 16'h0001, ovf=1. The next run with no carry shows ovf=0.
//  3. base=254, len=4 -> writes exactly addresses 254, 255, 0, 1. No other BRAM3 location changes.
//  4. len=0 -> done in cycle 1. ena1/ena2/ena3 never asserted. busy stays 0.
//  5. Extra start pulses during RUN, plus rst asserted mid-run at element 3.
//     -> extra starts ignored. After rst: no writes, no done. A fresh run then completes normally.
//  6. len=256, RD_LAT=2, random data -> 256 back-to-back writes, all sums match the model.
//     done in cycle 259.

Source files
------------

// File: rtl/bram_add_pkg.sv
// -----------------------------------------------------------------------------
// bram_add_pkg
// Shared definitions for the BRAM adder sequencer slice.
//   AW_DEF / DW_DEF : default BRAM address and data widths (256 x 16 BRAMs)
//   MAX_LEN         : largest element count a single run can cover (2**AW_DEF)
//   state_t         : sequencer FSM states
// -----------------------------------------------------------------------------
package bram_add_pkg;

  localparam int AW_DEF  = 8;
  localparam int DW_DEF  = 16;
  localparam int MAX_LEN = 2 ** AW_DEF;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/bram_add_delay_line.sv
// -----------------------------------------------------------------------------
// bram_add_delay_line
// Carries {valid, addr} of each issued read forward DEPTH cycles so that the
// write stage knows when and where each sum has to land in BRAM3.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset (clears valid and addr)
//   i_valid      : a read is issued for the following cycle
//   i_addr       : address of that read
//   o_valid      : write-stage valid, DEPTH cycles after i_valid
//   o_addr       : write-stage address, DEPTH cycles after i_addr
// -----------------------------------------------------------------------------
module bram_add_delay_line
  import bram_add_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = AW_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_valid,
  input  logic [AW-1:0] i_addr,
  output logic          o_valid,
  output logic [AW-1:0] o_addr
);

  logic [DEPTH-1:0] r_valid;
  logic [AW-1:0]    r_addr [DEPTH];

  // Plain shift register. Clearing valid on reset is what guarantees that a
  // run abandoned by reset produces no further BRAM3 writes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_addr[k] <= '0;
      end
    end else begin
      r_valid[0] <= i_valid;
      r_addr[0]  <= i_addr;
      for (int k = 1; k < DEPTH; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_addr[k]  <= r_addr[k-1];
      end
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_addr  = r_addr[DEPTH-1];

endmodule

// File: rtl/bram_add_sequencer.sv
// -----------------------------------------------------------------------------
// bram_add_sequencer
// Streams operand words out of BRAM1/BRAM2, adds them and writes each sum to
// BRAM3 at the same address, one element per cycle with no bubbles.
// Ports:
//   i_clk, i_rst   : shared BRAM clock, synchronous active-high reset
//   i_start        : run request, only looked at in IDLE
//   i_base, i_len  : first address and element count (0..2**AW), taken on start
//   o_busy, o_done : run in progress / one-cycle completion pulse
//   o_ovf          : sticky carry-out of any sum during the current run
//   o_ena1, o_ena2, o_addra12, i_douta1, i_douta2 : BRAM1/BRAM2 read port
//   o_ena3, o_wea3, o_addra3, o_dina3             : BRAM3 write port
// -----------------------------------------------------------------------------
module bram_add_sequencer
  import bram_add_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int RD_LAT = 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [AW-1:0] i_base,
  input  logic [AW:0]   i_len,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_ovf,
  output logic          o_ena1,
  output logic          o_ena2,
  output logic [AW-1:0] o_addra12,
  input  logic [DW-1:0] i_douta1,
  input  logic [DW-1:0] i_douta2,
  output logic          o_ena3,
  output logic          o_wea3,
  output logic [AW-1:0] o_addra3,
  output logic [DW-1:0] o_dina3
);

  localparam int DCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_t         r_state;
  logic [AW:0]    r_remaining;
  logic [DCW-1:0] r_drainCnt;
  logic           r_ena12;
  logic [AW-1:0]  r_addra12;
  logic           r_busy;
  logic           r_done;
  logic           r_ovf;

  logic           w_issueValid;
  logic [AW-1:0]  w_issueAddr;
  logic           w_wrValid;
  logic [AW-1:0]  w_wrAddr;
  logic [DW:0]    w_sum;

  // Next read to put on the BRAM1/BRAM2 port. These are the values the read
  // registers take at the coming edge; the delay line is fed from here so a
  // depth of RD_LAT+1 lines its output up with the cycle the data is valid.
  always_comb begin
    w_issueValid = 1'b0;
    w_issueAddr  = r_addra12;
    if (!i_rst) begin
      case (r_state)
        IDLE: begin
          if (i_start && (i_len != '0)) begin
            w_issueValid = 1'b1;
            w_issueAddr  = i_base;
          end
        end
        RUN: begin
          if (r_remaining != '0) begin
            w_issueValid = 1'b1;
            w_issueAddr  = r_addra12 + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  bram_add_delay_line #(
    .DEPTH (RD_LAT + 1),
    .AW    (AW)
  ) u_delay (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (w_issueValid),
    .i_addr  (w_issueAddr),
    .o_valid (w_wrValid),
    .o_addr  (w_wrAddr)
  );

  // BRAM read data is already registered inside the BRAMs, so the sum is
  // formed in the write cycle itself; this keeps the last write at
  // len+RD_LAT. The top bit is the carry that feeds the sticky flag.
  assign w_sum = {1'b0, i_douta1} + {1'b0, i_douta2};

  // Sequencer FSM with registered read-port and status outputs. RUN counts
  // down the reads still to issue, DRAIN waits RD_LAT cycles for the last
  // sum to be written, DONE is the single pulse cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_drainCnt  <= '0;
      r_ena12     <= 1'b0;
      r_addra12   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_ena12   <= w_issueValid;
      r_addra12 <= w_issueAddr;
      if (w_wrValid) begin
        r_ovf <= r_ovf | w_sum[DW];
      end
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_ovf <= 1'b0;
            if (i_len == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state     <= RUN;
              r_busy      <= 1'b1;
              r_remaining <= i_len - (AW+1)'(1);
            end
          end
        end
        RUN: begin
          if (r_remaining == '0) begin
            r_state    <= DRAIN;
            r_drainCnt <= DCW'(RD_LAT - 1);
          end else begin
            r_remaining <= r_remaining - (AW+1)'(1);
          end
        end
        DRAIN: begin
          if (r_drainCnt == '0) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_drainCnt <= r_drainCnt - DCW'(1);
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_ovf     = r_ovf;
  assign o_ena1    = r_ena12;
  assign o_ena2    = r_ena12;
  assign o_addra12 = r_addra12;
  assign o_ena3    = w_wrValid;
  assign o_wea3    = w_wrValid;
  assign o_addra3  = w_wrAddr;
  assign o_dina3   = w_wrValid ? w_sum[DW-1:0] : '0;

endmodule

// File: tb/tb_bram_add_sequencer.sv
// -----------------------------------------------------------------------------
// tb_bram_add_sequencer
// Drives one sequencer with RD_LAT=1 and one with RD_LAT=2 from the same
// stimulus, each wired to behavioural 256x16 BRAM models. Expected port
// activity and BRAM3 contents come from the element/cycle rules of the block.
// -----------------------------------------------------------------------------
module tb_bram_add_sequencer;
  import bram_add_pkg::*;

  localparam int FILL_KEEP  = 0;
  localparam int FILL_RAMP  = 1;
  localparam int FILL_CARRY = 2;
  localparam int FILL_RAND  = 3;

  typedef struct {
    int    base;
    int    len;
    int    fill;
    int    extraAt;
    int    rstAt;
    int    expOvf;
    int    expDone1;
    int    expDone2;
    string name;
  } vecT;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  base;
  logic [8:0]  len;
  logic        clear3;

  logic        busy [2];
  logic        done [2];
  logic        ovf [2];
  logic        ena1 [2];
  logic        ena2 [2];
  logic        ena3 [2];
  logic        wea3 [2];
  logic [7:0]  addra12 [2];
  logic [7:0]  addra3 [2];
  logic [15:0] douta1 [2];
  logic [15:0] douta2 [2];
  logic [15:0] dina3 [2];

  logic [15:0] mem1 [256];
  logic [15:0] mem2 [256];
  logic [15:0] mem3 [2][256];
  logic [15:0] exp3 [2][256];
  logic [15:0] stg1;
  logic [15:0] stg2;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  bram_add_sequencer #(.AW(8), .DW(16), .RD_LAT(1)) dutLat1 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_base(base), .i_len(len),
    .o_busy(busy[0]), .o_done(done[0]), .o_ovf(ovf[0]),
    .o_ena1(ena1[0]), .o_ena2(ena2[0]), .o_addra12(addra12[0]),
    .i_douta1(douta1[0]), .i_douta2(douta2[0]),
    .o_ena3(ena3[0]), .o_wea3(wea3[0]), .o_addra3(addra3[0]), .o_dina3(dina3[0])
  );

  bram_add_sequencer #(.AW(8), .DW(16), .RD_LAT(2)) dutLat2 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_base(base), .i_len(len),
    .o_busy(busy[1]), .o_done(done[1]), .o_ovf(ovf[1]),
    .o_ena1(ena1[1]), .o_ena2(ena2[1]), .o_addra12(addra12[1]),
    .i_douta1(douta1[1]), .i_douta2(douta2[1]),
    .o_ena3(ena3[1]), .o_wea3(wea3[1]), .o_addra3(addra3[1]), .o_dina3(dina3[1])
  );

  // Read-side BRAM models: one output register for RD_LAT=1, an extra
  // pipeline register in front of it for RD_LAT=2.
  always @(posedge clk) begin
    if (ena1[0]) douta1[0] <= mem1[addra12[0]];
    if (ena2[0]) douta2[0] <= mem2[addra12[0]];
    if (ena1[1]) stg1 <= mem1[addra12[1]];
    if (ena2[1]) stg2 <= mem2[addra12[1]];
    douta1[1] <= stg1;
    douta2[1] <= stg2;
  end

  // Write-side BRAM models, preset to a known background by clear3.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (clear3) begin
        for (int a = 0; a < 256; a++) mem3[d][a] <= 16'hA5A5;
      end else if (ena3[d] && wea3[d]) begin
        mem3[d][addra3[d]] <= dina3[d];
      end
    end
  end

  function automatic int modelSum(input int a);
    return (int'(mem1[a]) + int'(mem2[a])) % 65536;
  endfunction

  function automatic bit modelCarry(input int a);
    return (int'(mem1[a]) + int'(mem2[a])) >= 65536;
  endfunction

  task automatic checkOutput(input string name, input int d, input longint actual, input longint expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s (RD_LAT=%0d): got 'h%0h, expected 'h%0h", name, d + 1, actual, expected);
    end
  endtask

  task automatic fillMems(input int mode);
    for (int i = 0; i < 256; i++) begin
      case (mode)
        FILL_RAMP, FILL_CARRY: begin
          mem1[i] = 16'(i);
          mem2[i] = 16'(2 * i);
        end
        FILL_RAND: begin
          mem1[i] = 16'($urandom);
          mem2[i] = 16'($urandom);
        end
        default: ;
      endcase
    end
    if (mode == FILL_CARRY) begin
      mem1[5] = 16'hFFFF;
      mem2[5] = 16'h0002;
    end
  endtask

  // One run: start in cycle 0 (called just after a negedge), then every
  // cycle both DUTs are compared against the element timing rules. extraAt
  // pulses a decoy start, rstAt asserts reset for that one cycle.
  task automatic applyStimulus(input int b, input int n, input int extraAt, input int rstAt,
                               input int expOvf, input int expDone1, input int expDone2,
                               input string tag);
    int  expDone [2];
    int  doneSeen [2];
    int  lastCyc;
    int  mism;
    bit  modelOvf;
    bit  alive, rdOn, wrOn, busyOn, doneOn;
    int  lat;
    int  wa;

    expDone[0]  = expDone1;
    expDone[1]  = expDone2;
    doneSeen[0] = 0;
    doneSeen[1] = 0;
    modelOvf    = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (modelCarry((b + i) % 256)) modelOvf = 1'b1;
    end
    lastCyc = (rstAt >= 0) ? rstAt + 6 : expDone2 + 3;

    start = 1'b1;
    base  = 8'(b);
    len   = 9'(n);
    for (int c = 1; c <= lastCyc; c++) begin
      @(negedge clk);
      start = (c == extraAt);
      if (c == extraAt) begin
        base = 8'd100;
        len  = 9'd7;
      end
      rst = (c == rstAt);
      for (int d = 0; d < 2; d++) begin
        lat    = d + 1;
        alive  = (rstAt < 0) || (c <= rstAt);
        rdOn   = alive && (n > 0) && (c <= n);
        wrOn   = alive && (n > 0) && (c >= lat + 1) && (c <= n + lat);
        busyOn = alive && (n > 0) && (c <= n + lat);
        doneOn = alive && (c == expDone[d]);
        if (done[d]) doneSeen[d]++;
        checkOutput($sformatf("%s ena1 c%0d", tag, c), d, ena1[d], rdOn);
        checkOutput($sformatf("%s ena2 c%0d", tag, c), d, ena2[d], rdOn);
        checkOutput($sformatf("%s ena3 c%0d", tag, c), d, ena3[d], wrOn);
        checkOutput($sformatf("%s wea3 c%0d", tag, c), d, wea3[d], wrOn);
        checkOutput($sformatf("%s busy c%0d", tag, c), d, busy[d], busyOn);
        checkOutput($sformatf("%s done c%0d", tag, c), d, done[d], doneOn);
        if (rdOn) begin
          checkOutput($sformatf("%s addra12 c%0d", tag, c), d, addra12[d], (b + c - 1) % 256);
        end
        if (wrOn) begin
          wa = (b + c - lat - 1) % 256;
          checkOutput($sformatf("%s addra3 c%0d", tag, c), d, addra3[d], wa);
          checkOutput($sformatf("%s dina3 c%0d", tag, c), d, dina3[d], modelSum(wa));
        end
        if (alive && c == 1) begin
          checkOutput($sformatf("%s ovf cleared", tag), d, ovf[d], 0);
        end
        if (doneOn) begin
          checkOutput($sformatf("%s ovf at done", tag), d, ovf[d], (expOvf < 0) ? int'(modelOvf) : expOvf);
        end
        if (!alive) begin
          checkOutput($sformatf("%s post-reset addra12 c%0d", tag, c), d, addra12[d], 0);
          checkOutput($sformatf("%s post-reset addra3 c%0d", tag, c), d, addra3[d], 0);
          checkOutput($sformatf("%s post-reset dina3 c%0d", tag, c), d, dina3[d], 0);
          checkOutput($sformatf("%s post-reset ovf c%0d", tag, c), d, ovf[d], 0);
        end
      end
    end
    start = 1'b0;
    rst   = 1'b0;

    for (int d = 0; d < 2; d++) begin
      lat = d + 1;
      checkOutput($sformatf("%s done pulses", tag), d, doneSeen[d], (rstAt >= 0) ? 0 : 1);
      for (int i = 0; i < n; i++) begin
        if (rstAt < 0 || i + lat + 1 <= rstAt) exp3[d][(b + i) % 256] = 16'(modelSum((b + i) % 256));
      end
      mism = 0;
      for (int a = 0; a < 256; a++) begin
        if (mem3[d][a] !== exp3[d][a]) mism++;
      end
      checkOutput($sformatf("%s BRAM3 image mismatches", tag), d, mism, 0);
    end
  endtask

  vecT vecs [9];

  initial begin
    int rb, rn;

    vecs[0] = '{0,   4,       FILL_RAMP,  -1, -1, 0,  6,   7,   "ramp base0 len4"};
    vecs[1] = '{5,   1,       FILL_CARRY, -1, -1, 1,  3,   4,   "carry at 5"};
    vecs[2] = '{10,  3,       FILL_KEEP,  -1, -1, 0,  5,   6,   "no carry after carry"};
    vecs[3] = '{254, 4,       FILL_RAMP,  -1, -1, 0,  6,   7,   "wrap 254"};
    vecs[4] = '{0,   0,       FILL_KEEP,  -1, -1, 0,  1,   1,   "len0"};
    vecs[5] = '{20,  10,      FILL_RAMP,  2,  4,  0,  -1,  -1,  "reset mid-run"};
    vecs[6] = '{30,  5,       FILL_KEEP,  3,  -1, 0,  7,   8,   "fresh run with decoy start"};
    vecs[7] = '{250, 10,      FILL_RAMP,  -1, -1, 0,  12,  13,  "wrap 250"};
    vecs[8] = '{0,   MAX_LEN, FILL_RAND,  -1, -1, -1, 258, 259, "full depth random"};

    rst    = 1'b1;
    start  = 1'b0;
    base   = '0;
    len    = '0;
    clear3 = 1'b1;
    fillMems(FILL_RAMP);
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 256; a++) exp3[d][a] = 16'hA5A5;
    end
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    clear3 = 1'b0;
    @(negedge clk);

    for (int d = 0; d < 2; d++) begin
      checkOutput("reset busy", d, busy[d], 0);
      checkOutput("reset done", d, done[d], 0);
      checkOutput("reset ovf", d, ovf[d], 0);
      checkOutput("reset ena1", d, ena1[d], 0);
      checkOutput("reset ena2", d, ena2[d], 0);
      checkOutput("reset ena3", d, ena3[d], 0);
      checkOutput("reset wea3", d, wea3[d], 0);
      checkOutput("reset addra12", d, addra12[d], 0);
      checkOutput("reset addra3", d, addra3[d], 0);
      checkOutput("reset dina3", d, dina3[d], 0);
    end

    for (int v = 0; v < 9; v++) begin
      fillMems(vecs[v].fill);
      applyStimulus(vecs[v].base, vecs[v].len, vecs[v].extraAt, vecs[v].rstAt,
                    vecs[v].expOvf, vecs[v].expDone1, vecs[v].expDone2, vecs[v].name);
    end

    // start coincident with reset must not launch a run
    start = 1'b1;
    rst   = 1'b1;
    base  = 8'd7;
    len   = 9'd3;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 1'b0;
      rst   = 1'b0;
      for (int d = 0; d < 2; d++) begin
        checkOutput($sformatf("start+rst busy c%0d", c), d, busy[d], 0);
        checkOutput($sformatf("start+rst ena1 c%0d", c), d, ena1[d], 0);
        checkOutput($sformatf("start+rst ena3 c%0d", c), d, ena3[d], 0);
        checkOutput($sformatf("start+rst done c%0d", c), d, done[d], 0);
      end
    end

    // randomized runs with full-range data, carries judged by the model
    for (int r = 0; r < 6; r++) begin
      fillMems(FILL_RAND);
      rb = int'($urandom_range(0, 255));
      rn = int'($urandom_range(1, 40));
      $display("[TB] random run %0d: base=%0d len=%0d", r, rb, rn);
      applyStimulus(rb, rn, -1, -1, -1, rn + 2, rn + 3, $sformatf("random%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
